// File: rtl/alu_pkg.sv
// alu_pkg: shared opcodes, FSM encoding, size defaults and flat-index helper
package alu_pkg;
  localparam int DEF_DIM = 5;
  localparam int DEF_DATA_W = 8;
  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_TRANSPOSE = 2'd2;
  localparam logic [1:0] OP_NEG = 2'd3;
  typedef enum logic [2:0] {S_IDLE, S_LOAD_A, S_LOAD_B, S_EXEC, S_STORE} state_t;
  function automatic int idx(input int r, input int c, input int dim);
    return r * dim + c;
  endfunction
endpackage

// File: rtl/alu_matrix_sequencer_datapath.sv
// alu_matrix_datapath: combinational per-element ADD/SUB/NEG and transpose select
module alu_matrix_datapath import alu_pkg::*; #(
  parameter int DIM = DEF_DIM,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [DIM*DIM*DATA_W-1:0] a_flat_i,
  input  logic [DIM*DIM*DATA_W-1:0] b_flat_i,
  input  logic [1:0]                op_i,
  output logic [DIM*DIM*DATA_W-1:0] c_flat_o
);
  logic [DIM*DIM*DATA_W-1:0] t_flat;
  alu_transpose_module #(.DIM(DIM), .DATA_W(DATA_W)) u_tr (.a_flat_i(a_flat_i), .c_flat_o(t_flat));
  genvar i;
  for (i = 0; i < DIM*DIM; i++) begin : g_el
    logic [DATA_W-1:0] a, b;
    assign a = a_flat_i[i*DATA_W +: DATA_W];
    assign b = b_flat_i[i*DATA_W +: DATA_W];
    assign c_flat_o[i*DATA_W +: DATA_W] = op_i == OP_ADD ? a + b :
                                          op_i == OP_SUB ? a - b :
                                          op_i == OP_NEG ? '0 - a : t_flat[i*DATA_W +: DATA_W];
  end
endmodule

// File: rtl/alu_transpose_module.sv
// alu_transpose_module: full-grid combinational transpose of a flat DIM x DIM matrix
module alu_transpose_module import alu_pkg::*; #(
  parameter int DIM = DEF_DIM,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [DIM*DIM*DATA_W-1:0] a_flat_i,
  output logic [DIM*DIM*DATA_W-1:0] c_flat_o
);
  genvar i, j;
  for (i = 0; i < DIM; i++) begin : g_r
    for (j = 0; j < DIM; j++) begin : g_c
      assign c_flat_o[idx(i, j, DIM)*DATA_W +: DATA_W] = a_flat_i[idx(j, i, DIM)*DATA_W +: DATA_W];
    end
  end
endmodule

// File: rtl/alu_matrix_sequencer.sv
// alu_matrix_sequencer: command/load/execute/store sequencing around the matrix datapath
module alu_matrix_sequencer import alu_pkg::*; #(
  parameter int DIM = DEF_DIM,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [2:0]        cmd_size,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int N = DIM*DIM;
  localparam int W = N*DATA_W;
  state_t state_q, state_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, c_q, c_d, c_w;
  logic [2:0] row_q, row_d, col_q, col_d, n_q, n_d;
  logic [1:0] op_q, op_d;
  logic [DATA_W-1:0] elem;
  logic size_ok, last, col_end, cmd_fire, in_fire, out_fire;
  assign size_ok = cmd_size >= 3'd2 && int'(cmd_size) <= DIM;
  assign col_end = col_q == n_q - 3'd1;
  assign last = col_end && row_q == n_q - 3'd1;
  assign cmd_fire = cmd_valid && cmd_ready;
  assign in_fire = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  alu_matrix_datapath #(.DIM(DIM), .DATA_W(DATA_W)) u_dp (
    .a_flat_i(a_q), .b_flat_i(b_q), .op_i(op_q), .c_flat_o(c_w)
  );
  // FSM state register
  always_ff @(posedge clk)
    if (rst) state_q <= S_IDLE;
    else state_q <= state_d;
  // FSM next state: two-operand ops load B, single-operand ops go straight to EXEC
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = cmd_fire && size_ok ? S_LOAD_A : S_IDLE;
      S_LOAD_A: state_d = !(in_fire && last) ? S_LOAD_A :
                          (op_q == OP_ADD || op_q == OP_SUB) ? S_LOAD_B : S_EXEC;
      S_LOAD_B: state_d = in_fire && last ? S_EXEC : S_LOAD_B;
      S_EXEC:   state_d = S_STORE;
      S_STORE:  state_d = out_fire && last ? S_IDLE : S_STORE;
      default:  state_d = S_IDLE;
    endcase
  end
  // FSM outputs and row-major result element mux
  always_comb begin
    cmd_ready = state_q == S_IDLE;
    in_ready = state_q == S_LOAD_A || state_q == S_LOAD_B;
    out_valid = state_q == S_STORE;
    busy = state_q != S_IDLE;
    out_last = out_valid && last;
    done = out_valid && out_ready && last;
    err = state_q == S_IDLE && cmd_valid && !size_ok;
    elem = '0;
    for (int k = 0; k < N; k++)
      if (k == idx(int'(row_q), int'(col_q), DIM)) elem = c_q[k*DATA_W +: DATA_W];
    out_data = out_valid ? elem : '0;
  end
  // Operand/result storage and shared row/col walk for load and store
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    c_d = c_q;
    row_d = row_q;
    col_d = col_q;
    n_d = n_q;
    op_d = op_q;
    if (cmd_fire && size_ok) begin
      a_d = '0;
      b_d = '0;
      row_d = '0;
      col_d = '0;
      n_d = cmd_size;
      op_d = cmd_op;
    end
    if (in_fire)
      for (int k = 0; k < N; k++)
        if (k == idx(int'(row_q), int'(col_q), DIM)) begin
          if (state_q == S_LOAD_A) a_d[k*DATA_W +: DATA_W] = in_data;
          else b_d[k*DATA_W +: DATA_W] = in_data;
        end
    if (in_fire || out_fire) begin
      row_d = last ? '0 : col_end ? row_q + 3'd1 : row_q;
      col_d = col_end ? '0 : col_q + 3'd1;
    end
    if (state_q == S_EXEC) c_d = c_w;
  end
  // Storage registers
  always_ff @(posedge clk)
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
      row_q <= '0;
      col_q <= '0;
      n_q <= '0;
      op_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
      c_q <= c_d;
      row_q <= row_d;
      col_q <= col_d;
      n_q <= n_d;
      op_q <= op_d;
    end
endmodule

// File: tb/tb_alu_matrix_sequencer.sv
// tb_alu_matrix_sequencer: scoreboard bench for the matrix sequencer
module tb_alu_matrix_sequencer;
  import alu_pkg::*;
  logic clk = 0, rst = 1, cmd_valid = 0, in_valid = 0, out_ready = 0;
  logic [1:0] cmd_op = 0;
  logic [2:0] cmd_size = 0;
  logic [7:0] in_data = 0;
  logic cmd_ready, in_ready, out_valid, out_last, busy, done, err;
  logic [7:0] out_data;
  typedef struct packed {logic [7:0] d; logic l;} exp_t;
  exp_t exp_q[$];
  exp_t e;
  int checks = 0, errors = 0, err_cnt = 0, e0 = 0;
  bit rnd_rdy = 0, hold = 0;
  logic [7:0] prev_d, va[25], vb[25];

  alu_matrix_sequencer dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_size(cmd_size), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic l);
    exp_q.push_back('{d: d, l: l});
  endtask

  always @(posedge clk) begin
    #1;
    out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    if (err) err_cnt++;
    if (hold && out_valid) chk("hold_stable", 32'(out_data), 32'(prev_d));
    hold = out_valid && !out_ready;
    prev_d = out_data;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %0h expected none", out_data);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", 32'(out_data), 32'(e.d));
        chk("out_last", 32'(out_last), 32'(e.l));
        chk("done", 32'(done), 32'(e.l));
      end
    end
  end

  task automatic send_cmd(input logic [1:0] op, input logic [2:0] sz);
    int t = 0;
    @(posedge clk); #1;
    cmd_valid = 1; cmd_op = op; cmd_size = sz;
    while (!cmd_ready && t < 200) begin @(posedge clk); #1; t++; end
    if (!cmd_ready) chk("cmd_timeout", 0, 1);
    @(posedge clk); #1;
    cmd_valid = 0;
  endtask

  task automatic load(input int n, input bit use_b, input bit gaps);
    for (int i = 0; i < n; i++) begin
      int t = 0;
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 0;
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      end
      in_valid = 1;
      in_data = use_b ? vb[i] : va[i];
      while (!in_ready && t < 200) begin @(posedge clk); #1; t++; end
      if (!in_ready) chk("in_timeout", 0, 1);
      @(posedge clk); #1;
    end
    in_valid = 0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((exp_q.size() != 0 || !cmd_ready) && t < 1000) begin @(posedge clk); #1; t++; end
    chk("drain", 32'(exp_q.size() == 0 && cmd_ready), 1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_outs", 32'({busy, in_ready, out_valid, out_last, done, err, out_data}), 0);
    // abort a load with reset
    for (int i = 0; i < 9; i++) va[i] = 8'(50 + i);
    send_cmd(OP_ADD, 3);
    load(7, 0, 0);
    chk("mid_load_busy", 32'(busy), 1);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_cmd_ready", 32'(cmd_ready), 1);
    chk("abort_in_ready", 32'(in_ready), 0);
    // transpose n=2
    va[0] = 1; va[1] = 2; va[2] = 3; va[3] = 4;
    push(1, 0); push(3, 0); push(2, 0); push(4, 1);
    send_cmd(OP_TRANSPOSE, 2);
    load(4, 0, 0);
    wait_idle();
    // add n=2
    vb[0] = 10; vb[1] = 20; vb[2] = 30; vb[3] = 40;
    push(11, 0); push(22, 0); push(33, 0); push(44, 1);
    send_cmd(OP_ADD, 2);
    load(4, 0, 0);
    load(4, 1, 0);
    wait_idle();
    // sub n=5 with wrap and latency check
    for (int i = 0; i < 25; i++) begin va[i] = 0; vb[i] = 1; push(8'hFF, i == 24); end
    send_cmd(OP_SUB, 5);
    load(25, 0, 0);
    load(25, 1, 0);
    chk("exec_no_valid", 32'(out_valid), 0);
    @(posedge clk); #1;
    chk("latency_valid", 32'(out_valid), 1);
    wait_idle();
    // transpose n=3 with a stray command during STORE
    for (int i = 0; i < 9; i++) va[i] = 8'(i + 1);
    push(1, 0); push(4, 0); push(7, 0); push(2, 0); push(5, 0);
    push(8, 0); push(3, 0); push(6, 0); push(9, 1);
    send_cmd(OP_TRANSPOSE, 3);
    load(9, 0, 0);
    @(posedge clk); #1;
    cmd_valid = 1; cmd_op = OP_ADD; cmd_size = 2;
    chk("store_cmd_ready", 32'(cmd_ready), 0);
    repeat (2) begin @(posedge clk); #1; end
    cmd_valid = 0;
    wait_idle();
    @(posedge clk); #1;
    chk("stray_cmd_ignored", 32'(busy), 0);
    // neg n=3
    push(8'hFF, 0); push(8'hFE, 0); push(8'hFD, 0); push(8'hFC, 0); push(8'hFB, 0);
    push(8'hFA, 0); push(8'hF9, 0); push(8'hF8, 0); push(8'hF7, 1);
    send_cmd(OP_NEG, 3);
    load(9, 0, 0);
    wait_idle();
    // illegal sizes
    e0 = err_cnt;
    @(posedge clk); #1;
    cmd_valid = 1; cmd_op = OP_ADD; cmd_size = 1;
    #1 chk("err_size1", 32'(err), 1);
    @(posedge clk); #1;
    cmd_size = 6;
    #1 chk("err_size6", 32'(err), 1);
    @(posedge clk); #1;
    cmd_valid = 0;
    chk("err_idle_busy", 32'(busy), 0);
    chk("err_in_ready", 32'(in_ready), 0);
    @(posedge clk); #1;
    chk("err_pulses", 32'(err_cnt - e0), 2);
    // add n=4 with random gaps and backpressure
    rnd_rdy = 1;
    for (int i = 0; i < 16; i++) begin
      va[i] = 8'(i * 30 + 5);
      vb[i] = 8'(100 + i * 7);
      push(8'(va[i] + vb[i]), i == 15);
    end
    send_cmd(OP_ADD, 4);
    load(16, 0, 1);
    load(16, 1, 1);
    wait_idle();
    rnd_rdy = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end
endmodule

// File: doc/alu_matrix_sequencer.md
Name: alu_matrix_sequencer

Overview:
- Controller that sequences one matrix operation of the coprocessor ALU per command: ADD, SUB, TRANSPOSE or NEG.
- Accepts a command, streams operand matrices A (and B) element-by-element into 5x5 flat storage, and executes in one registered cycle.
- Streams result C back out row-major.
- Sits between the coprocessor instruction/memory front-end and the combinational matrix datapath, owning all sequencing and handshakes.

Parameters:
- DIM, 5, maximum matrix dimension; storage is DIM x DIM.
- DATA_W, 8, element width in bits (two's complement).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- cmd_valid  input  1  command offered
- cmd_ready  output  1  high only in IDLE
- cmd_op  input  2  opcode: 0 ADD, 1 SUB, 2 TRANSPOSE, 3 NEG
- cmd_size  input  3  matrix dimension n; valid range 2..DIM
- in_valid  input  1  operand element offered
- in_ready  output  1  high in LOAD_A/LOAD_B
- in_data  input  DATA_W  operand element, row-major
- out_valid  output  1  result element valid
- out_ready  input  1  consumer accepts element
- out_data  output  DATA_W  result element, row-major
- out_last  output  1  marks element (n-1,n-1)
- busy  output  1  state != IDLE
- done  output  1  one-cycle pulse on final output handshake
- err  output  1  one-cycle pulse on rejected command

Behaviour:
- Reset: state IDLE; A, B, C, row/col counters and stored op/size cleared. All outputs 0 except cmd_ready=1. Reset mid-operation aborts the operation with no done or err.
- Storage: element (r,c) lives at flat bits [(r*DIM+c)*DATA_W +: DATA_W]. On command accept, A and B are cleared so that elements outside n x n stay 0.
- States: IDLE, LOAD_A, LOAD_B, EXEC, STORE.
- IDLE:
  - cmd_valid & cmd_ready with valid size: latch op and n, row=col=0, go to LOAD_A.
  - Size outside 2..DIM: command is consumed, err=1 for one cycle, state stays IDLE.
- LOAD_A / LOAD_B:
  - Each in_valid & in_ready writes in_data to (row,col), then col++.
  - When col reaches n-1, col wraps to 0 and row++.
  - After element (n-1,n-1): counters reset, then next state is LOAD_B for ADD/SUB and EXEC for TRANSPOSE/NEG.
  - No timeout; in_valid low simply stalls.
- EXEC: exactly one cycle; C <= datapath result; go to STORE.
- Latency: last load handshake at cycle t -> out_valid=1 at t+2.
- Arithmetic: ADD is A+B, SUB is A-B, NEG is 0-A, all per element and truncated to DATA_W (wrap-around, no saturation, no flags). TRANSPOSE is C[i][j]=A[j][i] over the full DIM x DIM grid; zero padding keeps n<DIM correct.
- STORE:
  - out_valid=1; out_data = C(row,col).
  - Each out_valid & out_ready advances row/col as in load. out_last=1 when (row,col)=(n-1,n-1).
  - out_ready low holds out_data stable.
  - Final handshake: done=1 for that cycle, next state IDLE.
- Commands: a cmd_valid while not in IDLE is ignored (cmd_ready=0). in_valid outside the load states and out_ready outside STORE are ignored.

Decomposition:
- Shared package (alu_pkg):
  - opcode constants OP_ADD=0, OP_SUB=1, OP_TRANSPOSE=2, OP_NEG=3;
  - state encoding;
  - DIM and DATA_W defaults;
  - flat-index helper function idx(r,c).
- One sub-module, alu_matrix_datapath: purely combinational, inputs A_flat, B_flat and op, output C_flat. Its transpose path instantiates the existing alu_transpose_module.
- The sequencer holds only the FSM, counters and registers.

Test Plan:
- Reset during LOAD_A after 7 elements -> busy=0, cmd_ready=1. A following TRANSPOSE n=2 of [1,2,3,4] outputs 1,3,2,4 with no stale data.
- ADD n=2: A=[1,2,3,4], B=[10,20,30,40] -> out 11,22,33,44; out_last on the 4th element; done pulse on the same handshake.
- SUB n=5: A all 0x00, B all 0x01 -> 25 outputs of 0xFF (wrap-around). First out_valid exactly 2 cycles after the last B handshake.
- TRANSPOSE n=3: A = 1..9 row-major -> out 1,4,7,2,5,8,3,6,9. NEG of same A -> 0xFF,0xFE,...,0xF7.
- Command with cmd_size=1, then cmd_size=6 -> err pulses twice, state stays IDLE, in_ready=0. A second cmd_valid during STORE is ignored.
- Random in_valid/out_ready gaps on ADD n=4 -> results match the model; out_data stays stable while out_ready=0.
